madd_arbiter: RTL

MADD_ARBITER -- requirements
Module: madd_arbiter

---
 rtl/madd_arbiter_if.sv | 35 +++
 rtl/madd_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/madd_arbiter_if.sv
// Request/response bundle for the two-requester multiply-add arbiter.
// No logic of its own: the slave modport is the arbiter side, the master modport is the requester/consumer side.
// Flow control is valid/ready on both request channels and on the response channel.
interface madd_arbiter_if #(
  parameter int WIDTH_IN  = 48,
  parameter int WIDTH_OUT = 112,
  parameter int CNT_W     = 16
);
  logic                        req0_valid;
  logic                        req1_valid;
  logic                        req0_ready;
  logic                        req1_ready;
  logic signed [WIDTH_IN-1:0]  req0_a;
  logic signed [WIDTH_IN-1:0]  req0_b;
  logic signed [WIDTH_IN-1:0]  req1_a;
  logic signed [WIDTH_IN-1:0]  req1_b;
  logic signed [WIDTH_OUT-1:0] req0_c;
  logic signed [WIDTH_OUT-1:0] req1_c;
  logic                        resp_valid;
  logic                        resp_ready;
  logic                        resp_id;
  logic signed [WIDTH_OUT-1:0] resp_data;
  logic                        busy;
  logic [CNT_W-1:0]            op_count;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_c, req1_c, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data, busy, op_count
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_c, req1_c, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data, busy, op_count
  );
endinterface

// File: rtl/madd_arbiter.sv
// Round-robin arbiter in front of one shared two-stage signed multiply-add (a*b + c) pipeline.
// Latency: 2 cycles from the accept edge to resp_valid; one operation per cycle.
// Backpressure: a held response freezes both stages and drops both request readies.
module madd_arbiter #(
  parameter int WIDTH_IN  = 48,
  parameter int WIDTH_OUT = 112,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           rst,
  madd_arbiter_if.slave bus
);

  localparam int PW = 2 * WIDTH_IN;

  if (WIDTH_OUT < PW) begin : g_bad_width
    $error("madd_arbiter: WIDTH_OUT must be at least 2*WIDTH_IN");
  end

  // stage 1: product, offset, id
  logic                        s1_valid;
  logic                        s1_id;
  logic signed [PW-1:0]        s1_prod;
  logic signed [WIDTH_OUT-1:0] s1_c;
  // stage 2: final sum, id
  logic                        s2_valid;
  logic                        s2_id;
  logic signed [WIDTH_OUT-1:0] s2_sum;

  logic                        last_grant;
  logic [CNT_W-1:0]            op_count;

  logic                        en;
  logic                        gnt_vld;
  logic                        gnt;
  logic                        acc;
  logic signed [WIDTH_IN-1:0]  sel_a;
  logic signed [WIDTH_IN-1:0]  sel_b;
  logic signed [WIDTH_OUT-1:0] sel_c;
  logic signed [PW-1:0]        prod;
  logic signed [WIDTH_OUT-1:0] prod_ext;

  // The whole pipeline moves together; it only stalls when a result sits unconsumed in S2.
  assign en = !s2_valid || bus.resp_ready;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    gnt_vld = bus.req0_valid || bus.req1_valid;
    gnt     = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt = ~last_grant;
    end else if (bus.req1_valid) begin
      gnt = 1'b1;
    end
  end

  assign bus.req0_ready = en && gnt_vld && !gnt;
  assign bus.req1_ready = en && gnt_vld && gnt;
  assign acc = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);

  // Operand mux follows the grant; unused when nothing is accepted.
  always_comb begin
    sel_a = bus.req0_a;
    sel_b = bus.req0_b;
    sel_c = bus.req0_c;
    if (gnt) begin
      sel_a = bus.req1_a;
      sel_b = bus.req1_b;
      sel_c = bus.req1_c;
    end
  end

  // Operands are sign-extended to the full product width before multiplying.
  assign prod     = PW'(sel_a) * PW'(sel_b);
  assign prod_ext = WIDTH_OUT'(s1_prod);

  // Pipeline registers: S1 captures the accepted request, S2 the wrapped sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_prod  <= '0;
      s1_c     <= '0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_sum   <= '0;
    end else if (en) begin
      s1_valid <= acc;
      s1_id    <= gnt;
      s1_prod  <= prod;
      s1_c     <= sel_c;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_sum   <= prod_ext + s1_c;
    end
  end

  // Grant history moves only on a real accept, so a withdrawn request leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (acc) begin
      last_grant <= gnt;
    end
  end

  // Count consumed results; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count <= '0;
    end else if (s2_valid && bus.resp_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign bus.resp_valid = s2_valid;
  assign bus.resp_id    = s2_id;
  assign bus.resp_data  = s2_sum;
  assign bus.busy       = s1_valid || s2_valid;
  assign bus.op_count   = op_count;

endmodule
